bram_fifo_ctrl: RTL and testbench

Sequencing controller that turns the simple dual-port `bram` (1-cycle registered read) into a streaming FIFO. It owns the write and read pointers and drives the BRAM's write and read ports. It hides the read latency behind a 2-entry output stage and exposes valid/ready handshakes on both sides. It replaces ad-hoc address and counter logic at every BRAM-backed buffer in the datapath.

---
 rtl/bram_fifo_ctrl.sv | 168 ++++++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
// Turns a simple dual-port BRAM with a 1-cycle registered read into a
// streaming FIFO. Owns the write/read pointers, drives both BRAM ports and
// hides the read latency behind a 2-entry output stage (head + skid).
// Valid/ready handshakes on the write (s_*) and read (m_*) sides.

module bram_fifo_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 15,
    parameter int AFULL_LEVEL = 2040
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,

    // write side
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,

    // read side
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,

    // BRAM write port
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,

    // BRAM read port
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,

    // status
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;   // pointer width, MSB tells full from empty
    localparam int CW    = ADDR_WIDTH + 2;   // count width, covers DEPTH + output stage

    // Pointers and occupancy of the BRAM itself.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] mem_occ;

    // In-flight read: doutb carries a word this cycle that must be captured.
    logic          infl;

    // Output stage: head is presented on m_data, skid sits behind it.
    logic [1:0]            ostage_cnt;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] skid_q;

    // Next-state values for the output stage.
    logic [1:0]            ostage_cnt_d;
    logic [1:0]            cnt_after_pop;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] skid_d;

    // Handshakes and read scheduling.
    logic       push;
    logic       pop;
    logic [2:0] stage_demand;   // entries the output stage will hold next cycle

    // ------------------------------------------------------------------
    // Status derived from registered state only.
    // ------------------------------------------------------------------
    assign mem_occ     = wr_ptr - rd_ptr;   // modulo 2^PW, ranges 0..DEPTH
    assign full        = (mem_occ == PW'(DEPTH));
    assign almost_full = (mem_occ >= PW'(AFULL_LEVEL));
    assign count       = {1'b0, mem_occ} + CW'(infl) + CW'(ostage_cnt);
    assign empty       = (count == '0);

    // ------------------------------------------------------------------
    // Write side: the BRAM write port is a direct pass-through of the push.
    // ------------------------------------------------------------------
    assign s_ready = rst_n & ~flush & ~full;
    assign push    = s_valid & s_ready;
    assign wea     = push;
    assign addra   = wr_ptr[ADDR_WIDTH-1:0];
    assign dina    = s_data;

    // ------------------------------------------------------------------
    // Read side: the head of the output stage is the FIFO head.
    // ------------------------------------------------------------------
    assign m_valid = (ostage_cnt != 2'd0);
    assign m_data  = head_q;
    assign pop     = m_valid & m_ready;

    // A read is issued only if the word it returns is guaranteed a slot in
    // the output stage: entries held plus the one in flight, minus the one
    // leaving this cycle, must leave room. Occupancy comes from registered
    // pointers, so a read never targets the address written this cycle.
    assign stage_demand = {1'b0, ostage_cnt} + {2'b00, infl} - {2'b00, pop};
    assign enb          = (mem_occ != '0) & (stage_demand < 3'd2) & ~flush;
    assign addrb        = rd_ptr[ADDR_WIDTH-1:0];

    // Advance the pointers on push / read issue; flush empties the memory.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            infl   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            infl   <= 1'b0;   // drops the word on doutb next edge
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (enb) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            infl <= enb;
        end
    end

    // Output stage next state: shift on pop, then append the in-flight word
    // behind whatever entry remains.
    // NOTE: every variable gets a default at the top of the block, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d        = head_q;
        skid_d        = skid_q;
        cnt_after_pop = ostage_cnt - {1'b0, pop};
        ostage_cnt_d  = cnt_after_pop;

        if (pop) begin
            head_d = skid_q;
        end

        if (infl) begin
            if (cnt_after_pop == 2'd0) begin
                head_d = doutb;
            end else begin
                skid_d = doutb;
            end
            ostage_cnt_d = cnt_after_pop + 2'd1;
        end
    end

    // Register the output stage; flush invalidates it without touching data.
    // NOTE: the data registers are reset as well so m_data reads 0 out of
    // reset; only the occupancy count decides which entries are meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ostage_cnt <= 2'd0;
            head_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            ostage_cnt <= 2'd0;
        end else begin
            ostage_cnt <= ostage_cnt_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl: a behavioural BRAM, a queue-based
// reference model (words held = pushed - popped, in push order), a table of
// cycle-exact vectors for the single-word latency path, and directed plus
// randomized sequences for fill/drain, flush, streaming and stalls.

module tb_bram_fifo_ctrl;

    localparam int AW = 11;
    localparam int DW = 15;
    localparam int CW = AW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic [CW-1:0] count;
    logic          full;
    logic          almost_full;
    logic          empty;

    always #5 clk = ~clk;

    bram_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .AFULL_LEVEL(2040)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .enb        (enb),
        .addrb      (addrb),
        .doutb      (doutb),
        .count      (count),
        .full       (full),
        .almost_full(almost_full),
        .empty      (empty)
    );

    // Behavioural simple dual-port BRAM with 1-cycle registered read.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (wea) bram[addra] <= dina;
        if (enb) doutb <= bram[addrb];
    end

    // Bookkeeping and reference model.
    int            n_pass  = 0;
    int            n_total = 0;
    logic [DW-1:0] q[$];
    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_data;

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          e_s_ready;
        logic          e_wea;
        logic [AW-1:0] e_addra;
        logic          e_enb;
        logic [AW-1:0] e_addrb;
        logic          e_mv;
        logic [DW-1:0] e_md;
        int            e_cnt;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle. Called at a falling edge with inputs already driven:
    // samples the handshakes, checks the head against the model, advances the
    // model, and checks count/empty after the rising edge.
    task automatic tick(output bit did_push, output bit did_pop, output logic [DW-1:0] pop_data);
        #1;
        did_push = s_valid && s_ready;
        did_pop  = m_valid && m_ready;
        pop_data = m_data;
        if (m_valid) begin
            check("head_data", 32'(m_data), (q.size() != 0) ? 32'(q[0]) : 32'hDEAD_BEEF);
            if (hold_pend) check("stall_hold", 32'(m_data), 32'(hold_data));
        end
        hold_pend = m_valid && !m_ready;
        hold_data = m_data;
        if (flush) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (did_pop && q.size() != 0) void'(q.pop_front());
            if (did_push) q.push_back(s_data);
        end
        @(posedge clk);
        @(negedge clk);
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
    endtask

    // Drain whatever is held with m_ready high; optionally require no gaps.
    task automatic drain(input int budget, input bit no_gaps);
        bit p, o;
        logic [DW-1:0] d;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            tick(p, o, d);
            if (no_gaps) check("drain_gap", 32'(o), 32'd1);
        end
        check("drain_done", 32'(q.size()), 32'd0);
    endtask

    // Single word into an empty FIFO with freshly cleared pointers.
    task automatic run_table();
        bit p, o;
        logic [DW-1:0] d;
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = tbl[i].sv;
            s_data  = tbl[i].sd;
            m_ready = tbl[i].mr;
            #1;
            check($sformatf("tbl%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_s_ready));
            check($sformatf("tbl%0d_wea", i),     32'(wea),     32'(tbl[i].e_wea));
            check($sformatf("tbl%0d_addra", i),   32'(addra),   32'(tbl[i].e_addra));
            check($sformatf("tbl%0d_enb", i),     32'(enb),     32'(tbl[i].e_enb));
            check($sformatf("tbl%0d_addrb", i),   32'(addrb),   32'(tbl[i].e_addrb));
            check($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) check($sformatf("tbl%0d_m_data", i), 32'(m_data), 32'(tbl[i].e_md));
            check($sformatf("tbl%0d_count", i),   32'(count),   32'(tbl[i].e_cnt));
            tick(p, o, d);
        end
    endtask

    initial begin
        bit            p, o, got;
        logic [DW-1:0] d;
        int            k;

        //              sv  sd       mr  s_rdy wea addra enb addrb mv  md       cnt
        tbl[0] = '{1'b1, 15'h1234, 1'b1, 1'b1, 1'b1, 11'd0, 1'b0, 11'd0, 1'b0, 15'h0,    0};
        tbl[1] = '{1'b0, 15'h0,    1'b1, 1'b1, 1'b0, 11'd1, 1'b1, 11'd0, 1'b0, 15'h0,    1};
        tbl[2] = '{1'b0, 15'h0,    1'b1, 1'b1, 1'b0, 11'd1, 1'b0, 11'd1, 1'b0, 15'h0,    1};
        tbl[3] = '{1'b0, 15'h0,    1'b1, 1'b1, 1'b0, 11'd1, 1'b0, 11'd1, 1'b1, 15'h1234, 1};
        tbl[4] = '{1'b0, 15'h0,    1'b1, 1'b1, 1'b0, 11'd1, 1'b0, 11'd1, 1'b0, 15'h0,    0};

        // ---- reset ----
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = 15'h7FFF;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_s_ready",     32'(s_ready),     32'd0);
        check("rst_wea",         32'(wea),         32'd0);
        check("rst_enb",         32'(enb),         32'd0);
        check("rst_m_valid",     32'(m_valid),     32'd0);
        check("rst_m_data",      32'(m_data),      32'd0);
        check("rst_count",       32'(count),       32'd0);
        check("rst_empty",       32'(empty),       32'd1);
        check("rst_full",        32'(full),        32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_s_ready", 32'(s_ready), 32'd1);
        check("idle_enb",     32'(enb),     32'd0);
        check("idle_m_valid", 32'(m_valid), 32'd0);
        check("idle_empty",   32'(empty),   32'd1);
        @(negedge clk);

        // ---- single word latency path ----
        run_table();

        // ---- fill until refused, then drain gap-free ----
        k       = 0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 2200; i++) begin
            s_data = DW'(k);
            tick(p, o, d);
            if (!p) break;
            k++;
            if (q.size() >= 4) begin
                // Output stage is full and nothing is in flight: memory holds count-2.
                check("fill_almost_full", 32'(almost_full), 32'((q.size() - 2) >= 2040));
                check("fill_full",        32'(full),        32'((q.size() - 2) == 2048));
            end
        end
        #1;
        check("filled_count",       32'(count),       32'd2050);
        check("filled_full",        32'(full),        32'd1);
        check("filled_almost_full", 32'(almost_full), 32'd1);
        check("filled_s_ready",     32'(s_ready),     32'd0);
        @(negedge clk);
        drain(2200, 1'b1);

        // ---- flush with a read in flight and the head occupied ----
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 15'h11; tick(p, o, d);
        s_data  = 15'h22; tick(p, o, d);
        s_data  = 15'h33; tick(p, o, d);
        flush   = 1'b1;
        s_data  = 15'h44;
        #1;
        check("flush_s_ready", 32'(s_ready), 32'd0);
        check("flush_wea",     32'(wea),     32'd0);
        check("flush_enb",     32'(enb),     32'd0);
        tick(p, o, d);
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        check("post_flush_m_valid", 32'(m_valid), 32'd0);
        check("post_flush_empty",   32'(empty),   32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(p, o, d);
            check("no_stale_word", 32'(m_valid), 32'd0);
        end
        s_valid = 1'b1;
        s_data  = 15'hAB;
        tick(p, o, d);
        s_valid = 1'b0;
        got     = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick(p, o, d);
            if (o) begin
                check("flush_first_word", 32'(d), 32'h00AB);
                got = 1'b1;
            end
        end
        check("flush_word_seen", 32'(got), 32'd1);

        // ---- sustained streaming, pointers wrap ----
        for (int i = 0; i < 5000; i++) begin
            s_valid = 1'b1;
            s_data  = DW'($urandom);
            m_ready = 1'b1;
            tick(p, o, d);
            if (i >= 3) check("stream_rate", 32'({p, o}), 32'd3);
        end
        drain(10, 1'b1);

        // ---- random traffic and consumer stalls ----
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = DW'($urandom);
            m_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick(p, o, d);
        end
        drain(2200, 1'b0);

        // ---- reset mid-stream ----
        for (int i = 0; i < 60; i++) begin
            s_valid = ($urandom_range(0, 1) != 0);
            s_data  = DW'($urandom);
            m_ready = ($urandom_range(0, 2) == 0);
            tick(p, o, d);
        end
        rst_n   = 1'b0;
        s_valid = 1'b1;
        #1;
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_wea",     32'(wea),     32'd0);
        check("midrst_enb",     32'(enb),     32'd0);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_count",   32'(count),   32'd0);
        check("midrst_empty",   32'(empty),   32'd1);
        q.delete();
        hold_pend = 1'b0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_table();
        for (int i = 0; i < 300; i++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = DW'($urandom);
            m_ready = ($urandom_range(0, 1) != 0);
            tick(p, o, d);
        end
        drain(1000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "time limit");
    end

endmodule
